// File: rtl/pp_pkg.sv
// Shared types and decode for the ping/pong line-buffer sequencer.
package pp_pkg;

    typedef enum logic [1:0] {
        PP_IDLE,
        PP_FILL,
        PP_STREAM
    } pp_state_t;

    // sel value for which PING is the write side
    localparam logic SEL_PING_WR = 1'b0;

    // The four buffer enables, kept together so decode and registering stay in step
    typedef struct packed {
        logic ping_wr;
        logic pong_wr;
        logic ping_rd;
        logic pong_rd;
    } pp_en_t;

    localparam pp_en_t PP_EN_NONE = '{ping_wr: 1'b0, pong_wr: 1'b0, ping_rd: 1'b0, pong_rd: 1'b0};

    // Enables implied by a given state/sel pair; never a wr and rd on the same buffer
    function automatic pp_en_t pp_decode(input pp_state_t state, input logic sel);
        pp_en_t en;
        en = PP_EN_NONE;
        case (state)
            PP_FILL: begin
                en.ping_wr = 1'b1;
            end
            PP_STREAM: begin
                if (sel == SEL_PING_WR) begin
                    en.ping_wr = 1'b1;
                    en.pong_rd = 1'b1;
                end else begin
                    en.pong_wr = 1'b1;
                    en.ping_rd = 1'b1;
                end
            end
            default: en = PP_EN_NONE;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/pp_addr_counter.sv
// Phase counter: counts 0..MAX_ADDRESS while enabled and flags the wrap edge.
module pp_addr_counter #(
    parameter int ADDR_SIZE   = 4,
    parameter int MAX_ADDRESS = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic [ADDR_SIZE-1:0] count,
    output logic                 wrap
);

    // Equality compare against the last address, so short phases work too
    localparam logic [ADDR_SIZE-1:0] MAX_CNT = ADDR_SIZE'(MAX_ADDRESS);
    localparam logic [ADDR_SIZE-1:0] ONE     = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    if (MAX_ADDRESS < 0 || MAX_ADDRESS > (2**ADDR_SIZE) - 1) begin : g_bad_max_address
        $error("pp_addr_counter: MAX_ADDRESS does not fit in ADDR_SIZE bits");
    end

    logic [ADDR_SIZE-1:0] count_q;
    logic [ADDR_SIZE-1:0] count_d;

    assign wrap  = en && (count_q == MAX_CNT);
    assign count = count_q;

    // Next count: hold when idle, increment, or return to 0 on the wrap edge
    always_comb begin
        // NOTE: default first so every path assigns count_d; otherwise a latch is inferred.
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + ONE;
        end
    end

    // Counter register, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ping_pong_ctrl.sv
// Ping/pong line-buffer sequencer: one initial PING fill, then continuous
// write/read streaming with roles swapping every MAX_ADDRESS+1 cycles.
module ping_pong_ctrl
    import pp_pkg::*;
#(
    parameter int IMAGE_SIZE  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int EXP_SIZE    = 5,
    parameter int MANT_SIZE   = 10,
    parameter int DATA_SIZE   = 8,
    parameter int ADDR_SIZE   = 4,
    parameter int MAX_ADDRESS = 15,
    parameter int COLUMNS     = 4,
    parameter int ROWS        = 3
) (
    input  logic clk,
    input  logic rst,
    output logic ping_wr_en,
    output logic pong_wr_en,
    output logic ping_rd_en,
    output logic pong_rd_en
);

    // Datapath parameters are carried for interface uniformity only; reject nonsense values
    if (IMAGE_SIZE < 1 || KERNEL_SIZE < 1 || EXP_SIZE < 1 || MANT_SIZE < 1 ||
        DATA_SIZE < 1 || COLUMNS < 1 || ROWS < 1) begin : g_bad_params
        $error("ping_pong_ctrl: datapath parameters must be positive");
    end

    pp_state_t            state_q, state_d;
    logic                 sel_q, sel_d;
    pp_en_t               en_q, en_d;
    logic                 cnt_en;
    logic                 wrap;
    logic [ADDR_SIZE-1:0] count;
    logic                 unused_count_parity;

    // The counter runs in FILL and STREAM; it sits at 0 through the IDLE->FILL edge
    assign cnt_en = (state_q != PP_IDLE);

    pp_addr_counter #(
        .ADDR_SIZE  (ADDR_SIZE),
        .MAX_ADDRESS(MAX_ADDRESS)
    ) u_addr_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .count(count),
        .wrap (wrap)
    );

    // The address itself belongs to the buffers; only the wrap flag matters here
    assign unused_count_parity = ^count;

    // Next state, sel toggle on wrap, and enables decoded from the next state
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            PP_IDLE: begin
                state_d = PP_FILL;
            end
            PP_FILL: begin
                if (wrap) begin
                    state_d = PP_STREAM;
                    sel_d   = ~sel_q;
                end
            end
            PP_STREAM: begin
                if (wrap) begin
                    sel_d = ~sel_q;
                end
            end
            default: begin
                state_d = PP_IDLE;
                sel_d   = SEL_PING_WR;
            end
        endcase
        en_d = pp_decode(state_d, sel_d);
    end

    // FSM, sel and registered enables; reset clears everything without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PP_IDLE;
            sel_q   <= SEL_PING_WR;
            en_q    <= PP_EN_NONE;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
        end
    end

    assign ping_wr_en = en_q.ping_wr;
    assign pong_wr_en = en_q.pong_wr;
    assign ping_rd_en = en_q.ping_rd;
    assign pong_rd_en = en_q.pong_rd;

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Directed bench for ping_pong_ctrl: default instance (16-cycle phases) and a
// MAX_ADDRESS=9 instance (10-cycle phases) run side by side on one clock/reset.
module tb_ping_pong_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic a_ping_wr, a_pong_wr, a_ping_rd, a_pong_rd;
    logic b_ping_wr, b_pong_wr, b_ping_rd, b_pong_rd;

    int n_total = 0;
    int n_bad   = 0;

    always #2 clk = ~clk;

    ping_pong_ctrl u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .ping_wr_en(a_ping_wr),
        .pong_wr_en(a_pong_wr),
        .ping_rd_en(a_ping_rd),
        .pong_rd_en(a_pong_rd)
    );

    ping_pong_ctrl #(
        .ADDR_SIZE  (4),
        .MAX_ADDRESS(9)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .ping_wr_en(b_ping_wr),
        .pong_wr_en(b_pong_wr),
        .ping_rd_en(b_ping_rd),
        .pong_rd_en(b_pong_rd)
    );

    wire [3:0] a_vec = {a_ping_wr, a_pong_wr, a_ping_rd, a_pong_rd};
    wire [3:0] b_vec = {b_ping_wr, b_pong_wr, b_ping_rd, b_pong_rd};

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // Expected {ping_wr,pong_wr,ping_rd,pong_rd} k cycles after reset release.
    // Phase 0 is the PING fill; odd phases write PONG/read PING; even ones the reverse.
    function automatic logic [3:0] exp_en(input int k, input int max_addr);
        int phase;
        if (k < 1) return 4'b0000;
        phase = (k - 1) / (max_addr + 1);
        if (phase == 0)     return 4'b1000;
        if (phase % 2 == 1) return 4'b0110;
        return 4'b1001;
    endfunction

    // Advance n cycles after release, checking both instances and the invariants
    task automatic run_cycles(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_a_c%0d", tag, k), a_vec, exp_en(k, 15));
            check($sformatf("%s_b_c%0d", tag, k), b_vec, exp_en(k, 9));
            check($sformatf("%s_a_wr1hot_c%0d", tag, k), {3'b000, a_ping_wr ^ a_pong_wr}, 4'b0001);
            check($sformatf("%s_a_pingrw_c%0d", tag, k), {3'b000, a_ping_wr & a_ping_rd}, 4'b0000);
            check($sformatf("%s_a_pongrw_c%0d", tag, k), {3'b000, a_pong_wr & a_pong_rd}, 4'b0000);
            check($sformatf("%s_b_wr1hot_c%0d", tag, k), {3'b000, b_ping_wr ^ b_pong_wr}, 4'b0001);
        end
    endtask

    initial begin
        // Held in reset for three edges: all enables low
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_a", a_vec, 4'b0000);
        check("rst_hold_b", b_vec, 4'b0000);

        // Release between edges and stream for 800 ns (200 cycles)
        @(negedge clk);
        rst = 1'b0;
        run_cycles("run1", 200);

        // Asynchronous reset between edges: outputs drop before the next edge
        rst = 1'b1;
        #1;
        check("async_rst_a", a_vec, 4'b0000);
        check("async_rst_b", b_vec, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Run into STREAM, then reset at cycle 24 (PONG write / PING read phase)
        run_cycles("run2", 24);
        rst = 1'b1;
        #1;
        check("mid_rst_a", a_vec, 4'b0000);
        check("mid_rst_b", b_vec, 4'b0000);
        @(posedge clk);
        #1;
        check("mid_rst_edge_a", a_vec, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Restart: a full FILL phase recurs before any read
        run_cycles("run3", 48);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
